// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, ALU opcodes and the multiply sequencer states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL = 4'd0,
        ALU_SRL = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6
    } aluop_t;

    // Shift-add multiply sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } aluseq_state_t;

    // Counter value of the final ADD/SHIFT pair (32 pairs total)
    localparam logic [4:0] LAST_STEP = 5'd31;

endpackage

// File: rtl/alu_if.sv
// ALU request/response bundle; aluinit drives operations, aluresp answers them.
interface alu_if;
    import cpu_types_pkg::*;

    aluop_t opcode;
    word_t  op1;
    word_t  op2;
    word_t  res;
    logic   flag_v;
    logic   flag_n;
    logic   flag_z;

    modport aluinit (
        output opcode, op1, op2,
        input  res, flag_v, flag_n, flag_z
    );

    modport aluresp (
        input  opcode, op1, op2,
        output res, flag_v, flag_n, flag_z
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU; flag_v is the carry-out for ADD and the no-borrow carry for SUB.
module alu
    import cpu_types_pkg::*;
(
    alu_if.aluresp aluif
);

    logic [WORD_W:0] sum;

    // Operation decode; result is purely combinational
    always_comb begin
        sum          = '0;
        aluif.res    = '0;
        aluif.flag_v = 1'b0;
        case (aluif.opcode)
            ALU_ADD: begin
                sum          = {1'b0, aluif.op1} + {1'b0, aluif.op2};
                aluif.res    = sum[WORD_W-1:0];
                aluif.flag_v = sum[WORD_W];
            end
            ALU_SUB: begin
                sum          = {1'b0, aluif.op1} + {1'b0, ~aluif.op2} + {{WORD_W{1'b0}}, 1'b1};
                aluif.res    = sum[WORD_W-1:0];
                aluif.flag_v = sum[WORD_W];
            end
            ALU_SLL: aluif.res = aluif.op1 << aluif.op2[4:0];
            ALU_SRL: aluif.res = aluif.op1 >> aluif.op2[4:0];
            ALU_AND: aluif.res = aluif.op1 & aluif.op2;
            ALU_OR:  aluif.res = aluif.op1 | aluif.op2;
            ALU_XOR: aluif.res = aluif.op1 ^ aluif.op2;
            default: aluif.res = '0;
        endcase
    end

    assign aluif.flag_n = aluif.res[WORD_W-1];
    assign aluif.flag_z = (aluif.res == '0);

endmodule

// File: rtl/mult_seq.sv
// Unsigned 32x32 shift-add multiplier that borrows an external ALU for every add.
// {carry,hi,lo} is the running accumulator: lo starts as the multiplier and is
// shifted out one bit per step while product bits shift in from hi.
module mult_seq
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   nRST,
    input  logic   start,
    input  word_t  op_a,
    input  word_t  op_b,
    output logic   busy,
    output logic   done,
    output word_t  hi,
    output word_t  lo,
    alu_if.aluinit aluif
);

    aluseq_state_t state_q, state_d;
    word_t         mcand_q, mcand_d;
    word_t         hi_q, hi_d;
    word_t         lo_q, lo_d;
    logic          carry_q, carry_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Only the add carry-out matters here; N/Z flags are intentionally unused
    logic unused_flags;
    assign unused_flags = aluif.flag_n ^ aluif.flag_z;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // busy_q is still high during the done cycle, so a start there is dropped
                if (start && !busy_q) begin
                    mcand_d = op_a;
                    hi_d    = '0;
                    lo_d    = op_b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                hi_d    = aluif.res;
                carry_d = aluif.flag_v;
                state_d = SHIFT;
            end
            SHIFT: begin
                {carry_d, hi_d, lo_d} = {1'b0, carry_q, hi_q, lo_q[WORD_W-1:1]};
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = ADD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // done is registered, so it lands one cycle after DONE; busy covers that cycle too
        done_d = (state_q == DONE);
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    // ALU is only asked for real work in ADD; elsewhere it sees a harmless 0+0
    always_comb begin
        aluif.opcode = ALU_ADD;
        aluif.op1    = '0;
        aluif.op2    = '0;
        if (state_q == ADD) begin
            aluif.op1 = hi_q;
            aluif.op2 = lo_q[0] ? mcand_q : '0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: stimulus pushes expected product and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_mult_seq;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    logic  start = 1'b0;
    word_t op_a = '0;
    word_t op_b = '0;
    logic  busy, done;
    word_t hi, lo;

    alu_if alu_bus ();

    mult_seq dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .aluif (alu_bus)
    );

    alu u_alu (.aluif(alu_bus));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge CLK) begin
        if (nRST && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_done: done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("product", {hi, lo}, mon_e.prod);
                chk("latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    // Start is sampled at the next edge k; done is seen in the cycle after edge k+65
    task automatic issue(input word_t a, input word_t b, input bit track, input logic [63:0] prod);
        @(negedge CLK);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        if (track) sb.push_back('{prod: prod, due: cyc + 66});
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy still high after 200 cycles", name);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t       ra, rb;
        logic [63:0] rp;
        bit          seen;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("idle_op1", 64'(alu_bus.op1), 64'd0);
        chk("idle_op2", 64'(alu_bus.op2), 64'd0);
        chk("idle_opcode", 64'(alu_bus.opcode), 64'(ALU_ADD));
        @(negedge CLK);
        nRST = 1'b1;

        // 3*5
        issue(32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F);
        chk("busy_after_accept", 64'(busy), 64'd1);
        wait_idle("3x5");
        chk("hold_3x5", {hi, lo}, 64'h0000_0000_0000_000F);

        // All-ones squared; second start at cycle 10 must be ignored
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        repeat (9) @(negedge CLK);
        op_a  = 32'd7;
        op_b  = 32'd7;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_idle("ones");
        chk("hold_ones", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Zero multiplier
        issue(32'h1234_5678, 32'd0, 1'b1, 64'd0);
        wait_idle("zero");

        // Start presented in the done cycle is dropped
        issue(32'd9, 32'd9, 1'b1, 64'd81);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen_9x9", 64'(seen), 64'd1);
        op_a  = 32'd2;
        op_b  = 32'd2;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("done_cycle_start_busy", 64'(busy), 64'd0);
        chk("done_cycle_start_hold", {hi, lo}, 64'd81);
        @(negedge CLK);
        chk("done_cycle_start_still_idle", 64'(busy), 64'd0);

        // Reset at cycle 30 aborts with no done pulse
        issue(32'h0000_ABCD, 32'h0000_1234, 1'b0, 64'd0);
        repeat (29) @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        issue(32'd7, 32'd6, 1'b1, 64'd42);
        wait_idle("7x6");
        chk("hold_7x6", {hi, lo}, 64'd42);

        // Random unsigned pairs against a 64-bit reference product
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rp = {32'd0, ra} * {32'd0, rb};
            issue(ra, rb, 1'b1, rp);
            wait_idle("rand");
        end

        @(negedge CLK);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits (word_t from cpu_types_pkg).
REQ-002 SHALL have one clock; reset is asynchronous and active-low: port CLK input 1 (rising-edge clock), port nRST input 1 (async active-low reset).
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 op_a  input  32  multiplicand (unsigned), captured when start is accepted.
REQ-005 op_b  input  32  multiplier (unsigned), captured when start is accepted.
REQ-006 busy  output  1  high from the cycle after acceptance through the DONE cycle inclusive.
REQ-007 done  output  1  single-cycle pulse; hi/lo valid.
REQ-008 hi  output  32  upper product word.
REQ-009 lo  output  32  lower product word.
REQ-010 aluif  alu_if initiator modport (aluinit)  drives opcode, op1, op2; receives res, flag_v (add carry-out).

Function
REQ-011 SHALL compute the unsigned 64-bit product {hi,lo} = op_a * op_b by shift-add, using the external ALU for every addition.
REQ-012 SHALL implement states IDLE, ADD, SHIFT, DONE (aluseq_state_t).
REQ-013 IDLE: when start=1, load mcand=op_a, hi=0, lo=op_b, carry=0, cnt=0, then go to ADD; otherwise stay.
REQ-014 ADD: drive opcode=ALU_ADD, op1=hi, op2=(lo[0] ? mcand : 0); on the clock edge latch hi=res and carry=flag_v; then go to SHIFT.
REQ-015 SHIFT: {carry,hi,lo} shifted right 1 bit, with 0 into the MSB of carry; cnt increments; go to DONE if cnt was 31, else to ADD.
REQ-016 DONE: done=1 for exactly one cycle, then go to IDLE; hi/lo hold their value until the next accepted start.
REQ-017 Latency is fixed and data-independent: start sampled at edge k gives done=1 in the cycle after edge k+65 (32 ADD/SHIFT pairs plus DONE).
REQ-018 In IDLE, SHIFT and DONE, aluif SHALL be driven with opcode=ALU_ADD, op1=0, op2=0; its outputs are ignored.
REQ-019 start while busy=1, including in the DONE cycle, SHALL be ignored; there is no queueing.
REQ-020 cnt SHALL be 5 bits wide; it wraps from 31 to 0 only on the DONE transition and never mid-operation.
REQ-021 Signed multiply is out of scope; the operands are treated as unsigned.

Reset
REQ-022 nRST low SHALL asynchronously force state=IDLE, hi=0, lo=0, mcand=0, carry=0, cnt=0, busy=0, done=0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release is accepted normally.

Structure
REQ-024 aluseq_state_t SHALL live in cpu_types_pkg beside aluop_t; the ALU_ADD encoding comes from that package.
REQ-025 alu_if SHALL gain the aluinit modport: opcode, op1 and op2 as outputs; res, flag_v, flag_n and flag_z as inputs.
REQ-026 The design SHALL be one module: a registered state machine plus a combinational ALU-drive block, with no sub-modules; the bench instantiates the existing alu as the responder.

Verification
REQ-027 op_a=3, op_b=5, start pulsed at edge 0 -> done=1 only in the cycle after edge 65, hi=0x00000000, lo=0x0000000F.
REQ-028 op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (carry path exercised).
REQ-029 op_a=0x12345678, op_b=0 -> hi=0, lo=0, same 65-cycle latency.
REQ-030 start pulsed again at cycle 10 with new operands -> ignored; the first result is unchanged and there is exactly one done pulse.
REQ-031 nRST low at cycle 30 of an operation -> immediate IDLE, busy=0, hi=lo=0, no done; a new start of 7*6 then gives lo=42.
REQ-032 Random unsigned pairs (at least 1000) -> {hi,lo} matches the 64-bit reference product every time.
